// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline register between two adjacent pipe stages with a valid/ready
// handshake and a 2-entry skid buffer (main + skid). in_ready comes straight
// from a flop, so downstream stalls never ripple combinationally upstream.
// A per-stage flush drops every held payload at the next edge.
//
// Parameters:
//   DATA_W    payload width in bits (valid carried separately)
//   RST_DATA  reset / flush value of both payload registers
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-low
//   in_valid   upstream has a payload
//   in_data    upstream payload
//   in_ready   stage can accept (registered)
//   out_valid  stage holds a payload for downstream
//   out_data   payload presented downstream
//   out_ready  downstream accepts this cycle
//   flush      invalidate all held entries
//   stall_cnt  (only with PIPE_STAGE_SKID_STALL_CNT_EN) saturating count of
//              cycles with out_valid & ~out_ready; cleared by rst only
//
// Optional feature macro: PIPE_STAGE_SKID_STALL_CNT_EN
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int                DATA_W   = 319,
   parameter logic [DATA_W-1:0] RST_DATA = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
   ,
   output logic [15:0]       stall_cnt
`endif
);

   // State encoding is {main_v, skid_v}; 2'b01 has no name and must never occur.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b10,
      FULL  = 2'b11
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [DATA_W-1:0] main_d_reg;
   logic [DATA_W-1:0] main_d_next;
   logic [DATA_W-1:0] skid_d_reg;
   logic [DATA_W-1:0] skid_d_next;

   logic main_v;
   logic skid_v;
   logic acc;
   logic take;

   assign main_v    = state_reg[1];
   assign skid_v    = state_reg[0];

   assign in_ready  = ~skid_v;
   assign out_valid = main_v;
   assign out_data  = main_d_reg;

   assign acc  = in_valid & in_ready;
   assign take = out_valid & out_ready;

   // State and payload registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg  <= EMPTY;
         main_d_reg <= RST_DATA;
         skid_d_reg <= RST_DATA;
      end else begin
         state_reg  <= state_next;
         main_d_reg <= main_d_next;
         skid_d_reg <= skid_d_next;
      end
   end

   // Next-state and payload steering
   always_comb begin
      state_next  = state_reg;
      main_d_next = main_d_reg;
      skid_d_next = skid_d_reg;

      if (flush) begin
         // Any acc this cycle is dropped; a take still completes downstream.
         state_next  = EMPTY;
         main_d_next = RST_DATA;
         skid_d_next = RST_DATA;
      end else begin
         unique case (state_reg)
            EMPTY: begin
               if (acc) begin
                  state_next  = ONE;
                  main_d_next = in_data;
               end
            end
            ONE: begin
               if (acc && take) begin
                  main_d_next = in_data;
               end else if (acc) begin
                  state_next  = FULL;
                  skid_d_next = in_data;
               end else if (take) begin
                  state_next  = EMPTY;
               end
            end
            FULL: begin
               // in_ready is low here, so only a take can move us.
               if (take) begin
                  state_next  = ONE;
                  main_d_next = skid_d_reg;
               end
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
   logic [15:0] stall_cnt_reg;

   // Saturating stall counter; flush deliberately leaves it alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_reg <= '0;
      end else if (out_valid && !out_ready && (stall_cnt_reg != 16'hFFFF)) begin
         stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
   end

   assign stall_cnt = stall_cnt_reg;
`endif

`ifndef SYNTHESIS
   // A skid entry without a main entry would break FIFO ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         assert (!(!main_v && skid_v));
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//
// Self-checking bench for pipe_stage_skid at DATA_W=8, RST_DATA=0. The
// reference model is a bounded FIFO (queue, depth 2): pop on take, push on
// accept, clear on flush. Directed scenarios follow the test plan, then a
// randomized run compares the DUT to the model every cycle.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int DATA_W = 8;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_ready;
   logic              flush;
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
   logic [15:0]       stall_cnt;
`endif

   int errors = 0;
   int checks = 0;

   // Reference model: payloads held by the stage, oldest first.
   logic [DATA_W-1:0] mq[$];
   // Payloads observed leaving the DUT (sampled on take).
   logic [DATA_W-1:0] got[$];

   pipe_stage_skid #(
      .DATA_W   (DATA_W),
      .RST_DATA (8'h00)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .flush     (flush)
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One clock: model decides acc/take from its own occupancy, records what
   // the DUT actually hands over, advances the model, then waits #1.
   task automatic cycle();
      bit m_acc;
      bit m_take;
      m_acc  = in_valid && (mq.size() < 2);
      m_take = out_ready && (mq.size() > 0);
      if (out_valid && out_ready) got.push_back(out_data);
      @(posedge clk);
      if (m_take) void'(mq.pop_front());
      if (flush) mq.delete();
      else if (m_acc) mq.push_back(in_data);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #12;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mq.delete();
      got.delete();
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int v = 1; v <= 16; v++) begin
         in_data = v[7:0];
         cycle();
         checks++;
         if (out_valid !== 1'b1 || out_data !== v[7:0]) begin
            errors++;
            $display("FAIL stream_out got=%b/%02h exp=1/%02h", out_valid, out_data, v[7:0]);
         end
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready got=%b exp=1", in_ready); end
      end
      in_valid = 1'b0;
      cycle();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
      got.delete();
      idle_inputs();
   endtask

   task automatic test_back_pressure();
      logic [7:0] seq [3];
      seq[0] = 8'hA1; seq[1] = 8'hA2; seq[2] = 8'hA3;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = seq[0];
      cycle();
      in_data   = seq[1];
      cycle();
      in_data   = seq[2];           // upstream holds A3 while in_ready=0
      cycle();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA1) begin
         errors++; $display("FAIL bp_main got=%b/%02h exp=1/a1", out_valid, out_data);
      end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
      out_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 8; i++) begin
         if (in_valid && in_ready) begin
            cycle();
            in_valid = 1'b0;
         end else begin
            cycle();
         end
      end
      checks++;
      if (got.size() != 3) begin
         errors++; $display("FAIL bp_count got=%0d exp=3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (got[i] !== seq[i]) begin
               errors++; $display("FAIL bp_order idx=%0d got=%02h exp=%02h", i, got[i], seq[i]);
            end
         end
      end
      got.delete();
      idle_inputs();
   endtask

   task automatic test_flush_full();
      in_valid = 1'b1;
      in_data  = 8'hB1;
      cycle();
      in_data  = 8'hB2;
      cycle();
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ff_full got=%b exp=0", in_ready); end
      in_data = 8'hB3;
      flush   = 1'b1;
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL ff_after got=v%b r%b d%02h exp=v0 r1 d00", out_valid, in_ready, out_data);
      end
      out_ready = 1'b1;
      got.delete();
      repeat (4) cycle();
      checks++;
      if (got.size() != 0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL ff_leak got=%0d items exp=0", got.size());
      end
      idle_inputs();
   endtask

   task automatic test_flush_take();
      in_valid = 1'b1;
      in_data  = 8'hC1;
      cycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      flush     = 1'b1;
      got.delete();
      cycle();
      flush = 1'b0;
      checks++;
      if (got.size() != 1 || got[0] !== 8'hC1) begin
         errors++; $display("FAIL ft_take got=%0d items exp=1 item c1", got.size());
      end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL ft_after got=%b exp=0", out_valid); end
      got.delete();
      idle_inputs();
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 15) == 0);
         checks++;
         if (in_ready !== (mq.size() < 2) || out_valid !== (mq.size() > 0)) begin
            errors++;
            $display("FAIL rand_flags cyc=%0d got=r%b v%b exp=r%b v%b", n, in_ready, out_valid,
                     mq.size() < 2, mq.size() > 0);
         end else if (out_valid) begin
            checks++;
            if (out_data !== mq[0]) begin
               errors++; $display("FAIL rand_data cyc=%0d got=%02h exp=%02h", n, out_data, mq[0]);
            end
         end
         if (out_valid && out_ready) $display("xfer cyc=%0d data=%02h", n, out_data);
         cycle();
      end
      got.delete();
      idle_inputs();
   endtask

   task automatic test_async_reset();
      // Reach FULL, then pull reset between edges.
      in_valid = 1'b1;
      in_data  = 8'hD1;
      cycle();
      in_data  = 8'hD2;
      cycle();
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL async_rst got=v%b r%b d%02h exp=v0 r1 d00", out_valid, in_ready, out_data);
      end
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_rel got=%b exp=0", out_valid); end
      idle_inputs();
   endtask

`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
   task automatic test_stall_cnt();
      rst = 1'b0;
      #1;
      rst = 1'b1;
      mq.delete();
      @(posedge clk);
      #1;
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_init got=%0d exp=0", stall_cnt); end
      in_valid = 1'b1;
      in_data  = 8'h55;
      cycle();
      in_valid = 1'b0;
      repeat (5) cycle();
      checks++;
      if (stall_cnt !== 16'd5) begin errors++; $display("FAIL cnt_5 got=%0d exp=5", stall_cnt); end
      repeat (70000) @(posedge clk);
      #1;
      checks++;
      if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_sat got=%h exp=ffff", stall_cnt); end
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      cycle();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL cnt_flush got=%h exp=ffff", stall_cnt); end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (stall_cnt !== 16'd0) begin errors++; $display("FAIL cnt_rst got=%0d exp=0", stall_cnt); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      mq.delete();
      idle_inputs();
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_back_pressure();
      test_flush_full();
      test_flush_take();
      test_random();
      test_async_reset();
`ifdef PIPE_STAGE_SKID_STALL_CNT_EN
      test_stall_cnt();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed-width pipeline latch used between pipe stages.
- Adds a valid/ready handshake and a 2-entry skid buffer, so in_ready is a register output rather than a combinational stall path.
- Adds a per-stage flush and an optional back-pressure counter.
- One instance sits between adjacent pipe stages; the payload is the packed stage bundle (CS, addresses, sources, EIPs, etc.) minus the valid bit.

Parameters:
- DATA_W, 319: payload width in bits; valid is carried separately.
- RST_DATA, 0: reset and flush value of both payload registers (DATA_W bits).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  upstream has a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  stage can accept; registered.
- out_valid  out  1  stage holds a payload for downstream.
- out_data  out  DATA_W  payload presented downstream.
- out_ready  in  1  downstream accepts this cycle.
- flush  in  1  invalidate all held entries (branch mispredict / fault).

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
- Outputs:
  - out_valid = main_v; out_data = main_d.
  - in_ready = ~skid_v. Derived from flops only; no combinational path from out_ready.
- Handshake events, evaluated each rising clk edge:
  - acc = in_valid & in_ready.
  - take = out_valid & out_ready.
  - Data transfers only on acc or take.
- Reset (rst=0), asynchronous:
  - main_v = skid_v = 0; main_d = skid_d = RST_DATA.
  - Resulting outputs: in_ready=1, out_valid=0, out_data=RST_DATA.
  - Reset released mid-transfer: all held payloads are lost; no partial state survives.
- States (encoded by {main_v, skid_v}):
  - EMPTY {0,0}
    - acc -> ONE; main_d <= in_data.
  - ONE {1,0}
    - acc & take -> ONE; main_d <= in_data.
    - acc & ~take -> FULL; skid_d <= in_data.
    - ~acc & take -> EMPTY.
    - neither -> ONE, data held.
  - FULL {1,1}
    - in_ready=0, so acc is impossible.
    - take -> ONE; main_d <= skid_d; skid_v <= 0.
    - else hold.
- {0,1} is illegal and must be unreachable. Simulation assertion required.
- Latency: in_data accepted at edge N is visible on out_data after edge N; minimum 1 cycle.
- Throughput: 1 payload per cycle while out_ready=1.
- Ordering: strict FIFO. Skid content always leaves after main content.
- Flush:
  - At the next edge, main_v = skid_v = 0 and both data registers load RST_DATA, whatever acc/take say.
  - A payload offered in the flush cycle is dropped, but upstream sees acc=1 (in_ready is still 1 that cycle). Upstream must treat it as consumed.
  - A take in the flush cycle is valid: downstream receives the payload.
  - Flush has priority over all transitions; flush while in reset has no effect.
- Hold: payload registers are written only on the transitions listed above. out_data is stable while out_valid & ~out_ready.

Optional Feature:
- Macro: PIPE_STAGE_SKID_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [15:0].
  - Increments each cycle with out_valid & ~out_ready; saturates at 16'hFFFF.
  - Cleared to 0 by rst only; flush does not clear it.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset: drive rst=0 mid-simulation with FULL state -> out_valid=0, in_ready=1, out_data=0 immediately, without waiting for a clk edge.
- Streaming: DATA_W=8, out_ready=1, in_data 0x01..0x10 on consecutive cycles -> out_data 0x01..0x10 one cycle later, no bubbles, in_ready stays 1.
- Back-pressure:
  - Send 0xA1, 0xA2, 0xA3 with out_ready=0 -> 0xA1 in main, 0xA2 in skid, in_ready=0; 0xA3 held by upstream.
  - Raise out_ready -> out_data sequence 0xA1, 0xA2, 0xA3 with no loss or duplication.
- Flush in FULL: hold 0xB1/0xB2, assert flush with in_valid=1 (in_data=0xB3) -> next cycle out_valid=0, in_ready=1; 0xB3 never appears at the output.
- Flush with take: main=0xC1, out_ready=1, flush=1 -> 0xC1 is consumed in that cycle; out_valid=0 after the edge.
- Counter (with PIPE_STAGE_SKID_STALL_CNT_EN):
  - Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF.
  - Pulse flush -> count unchanged.
  - Assert rst -> count 0.
